tx_message_control: RTL and testbench
=====================================

TX_MESSAGE_CONTROL -- requirements
Module: tx_message_control

Interface
REQ-001 SHALL have parameter MAXRETRY, default 15, range 1..15; failed attempts allowed before giving up.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu  input  1  CPU write strobe, one cycle per write.
REQ-005 SHALL have port din  input  16  CPU write data, same bit map as regout.
REQ-006 SHALL have port txstart  input  1  llc pulse: frame transmission/arbitration begun.
REQ-007 SHALL have port txok  input  1  llc pulse: frame sent and acknowledged.
REQ-008 SHALL have port txlost  input  1  mac pulse: arbitration lost.
REQ-009 SHALL have port txerr  input  1  llc pulse: error frame during transmission.
REQ-010 SHALL have port txreq  output  1  request to llc/mac to transmit buffer.
REQ-011 SHALL have port irq  output  1  one-cycle transmit-complete interrupt pulse.
REQ-012 SHALL have port regout  output  16  transmit message control register.

Function
REQ-013 regout map SHALL be: [15] TRQ, [14] TSUC, [13] TABT, [12] TERR, [11:8] attempt count, [7] ien, [6] 0, [5] rtr, [4] ext, [3:0] dlc.
REQ-014 FSM SHALL have states IDLE, PENDING, ACTIVE; TRQ = 1 exactly in PENDING or ACTIVE; txreq = 1 exactly in PENDING.
REQ-015 IDLE: cpu with din[15]=1 SHALL go to PENDING next cycle, clear TSUC/TABT/TERR and attempt count, latch ien/rtr/ext/dlc from din in the same write.
REQ-016 Config fields ien/rtr/ext/dlc SHALL be writable only in IDLE; writes in PENDING/ACTIVE leave them unchanged.
REQ-017 In any state, cpu with din[14]=0, din[13]=0 or din[12]=0 SHALL clear TSUC, TABT or TERR respectively; writing 1 has no effect on these bits.
REQ-018 PENDING: txstart SHALL go to ACTIVE; cpu with din[13]=1 SHALL go to IDLE and set TABT; txstart wins over abort in the same cycle.
REQ-019 ACTIVE: cpu with din[13]=1 SHALL set internal abort-pending flag only; frame is never cut.
REQ-020 ACTIVE: txok SHALL go to IDLE and set TSUC, abort-pending discarded.
REQ-021 ACTIVE: txlost or txerr SHALL increment attempt count; if abort-pending -> IDLE and set TABT; else if new count = MAXRETRY -> IDLE and set TERR; else -> PENDING.
REQ-022 Priority within ACTIVE SHALL be txok > txerr > txlost; simultaneous events count as one attempt.
REQ-023 Attempt count SHALL saturate at 15, never wrap.
REQ-024 txstart outside PENDING and txok/txlost/txerr outside ACTIVE SHALL be ignored.
REQ-025 Sticky-bit set by a state transition SHALL win over a CPU clear in the same cycle.
REQ-026 irq SHALL pulse high for exactly one cycle, in the cycle after entering IDLE from PENDING/ACTIVE, when ien = 1.
REQ-027 regout SHALL be registered; all state changes visible one cycle after the causing event.
REQ-028 Unspecified bits ([6]) SHALL read 0.

Reset
REQ-029 rst = 0 SHALL immediately force IDLE, regout = 16'h0000, txreq = 0, irq = 0, abort-pending = 0, independent of clk.
REQ-030 Reset asserted mid-frame (ACTIVE) SHALL drop the request with no irq and no sticky bit set.

Verification
REQ-031 Write din=16'h80A3 in IDLE -> next cycle regout=16'h80A3, txreq=1; txstart -> txreq=0; txok -> regout=16'h40A3, irq pulse 1 cycle.
REQ-032 Request, then txstart/txlost three times each followed by txstart/txok -> regout[11:8]=3, TSUC=1, TRQ=0.
REQ-033 MAXRETRY=2: request, txstart/txerr twice -> state IDLE, TERR=1, count=2, txreq=0.
REQ-034 Abort in PENDING -> IDLE, TABT=1; abort in ACTIVE then txok -> TSUC=1, TABT=0; abort in ACTIVE then txlost -> TABT=1, no retry.
REQ-035 Write din=16'h0011 while ACTIVE -> config unchanged; txok and CPU TSUC-clear same cycle -> TSUC=1.
REQ-036 rst low asynchronously during ACTIVE -> regout=0, txreq=0 before next clk edge; subsequent txok ignored.

Source files
------------

// File: rtl/tx_message_control.sv
// tx_message_control: CAN transmit buffer control register with request/retry/abort FSM.
module tx_message_control #(
  parameter int MAXRETRY = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu,
  input  logic [15:0] din,
  input  logic        txstart,
  input  logic        txok,
  input  logic        txlost,
  input  logic        txerr,
  output logic        txreq,
  output logic        irq,
  output logic [15:0] regout
);
  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_t;
  localparam logic [3:0] MAXR = 4'(MAXRETRY);
  state_t     state, state_n;
  logic       tsuc, tabt, terr, abort_pend;
  logic [3:0] cnt, cnt_inc;
  logic [7:0] cfg;
  logic       abort_wr, start_req, abt_any, fail;
  always_comb begin
    abort_wr  = cpu && din[13];
    start_req = state == IDLE && cpu && din[15];
    cnt_inc   = cnt + {3'b000, cnt != 4'd15};
    abt_any   = abort_pend || abort_wr;
    fail      = state == ACTIVE && !txok && (txerr || txlost);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = start_req ? PENDING : IDLE;
      PENDING: state_n = txstart ? ACTIVE : abort_wr ? IDLE : PENDING;
      ACTIVE:  state_n = txok ? IDLE : !(txerr || txlost) ? ACTIVE :
                         (abt_any || cnt_inc == MAXR) ? IDLE : PENDING;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    txreq  = state == PENDING;
    regout = {state != IDLE, tsuc, tabt, terr, cnt, cfg & 8'hBF};
  end
  // status bits: a transition-driven set always overrides a same-cycle CPU clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tsuc       <= 1'b0;
      tabt       <= 1'b0;
      terr       <= 1'b0;
      cnt        <= 4'd0;
      cfg        <= 8'h00;
      abort_pend <= 1'b0;
      irq        <= 1'b0;
    end else begin
      tsuc       <= (state == ACTIVE && txok) || (tsuc && !(cpu && !din[14]) && !start_req);
      tabt       <= (state == PENDING && !txstart && abort_wr) || (fail && abt_any) ||
                    (tabt && !(cpu && !din[13]) && !start_req);
      terr       <= (fail && !abt_any && cnt_inc == MAXR) || (terr && !(cpu && !din[12]) && !start_req);
      cnt        <= start_req ? 4'd0 : fail ? cnt_inc : cnt;
      if (state == IDLE && cpu) cfg <= din[7:0];
      abort_pend <= state == ACTIVE && state_n == ACTIVE && abt_any;
      irq        <= cfg[7] && state != IDLE && state_n == IDLE;
    end
endmodule

// File: tb/tb_tx_message_control.sv
// tb_tx_message_control: randomized + directed checks of two instances (MAXRETRY 15 and 2) against a rule-level model.
module tb_tx_message_control;
  logic        clk, rst, cpu, txstart, txok, txlost, txerr;
  logic [15:0] din;
  logic        txreq0, irq0, txreq1, irq1;
  logic [15:0] ro0, ro1;
  int tests = 0, errors = 0;

  tx_message_control dut0 (.clk(clk), .rst(rst), .cpu(cpu), .din(din), .txstart(txstart), .txok(txok),
    .txlost(txlost), .txerr(txerr), .txreq(txreq0), .irq(irq0), .regout(ro0));
  tx_message_control #(.MAXRETRY(2)) dut1 (.clk(clk), .rst(rst), .cpu(cpu), .din(din), .txstart(txstart),
    .txok(txok), .txlost(txlost), .txerr(txerr), .txreq(txreq1), .irq(irq1), .regout(ro1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // model: 0 = idle, 1 = request pending, 2 = frame on bus
  int         m_st[2], m_cnt[2];
  int         maxr[2] = '{15, 2};
  logic       m_suc[2], m_abt[2], m_err[2], m_ab[2], m_irq[2];
  logic [7:0] m_cfg[2];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_reg(input int k);
    logic [7:0] c;
    c = m_cfg[k];
    return {m_st[k] != 0, m_suc[k], m_abt[k], m_err[k], 4'(m_cnt[k]), c[7], 1'b0, c[5:0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_suc[k] = 0; m_abt[k] = 0; m_err[k] = 0;
      m_ab[k] = 0; m_irq[k] = 0; m_cfg[k] = 0;
    end
  endtask

  task automatic model_step();
    int ns;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      ns = m_st[k];
      if (cpu) begin
        if (!din[14]) m_suc[k] = 0;
        if (!din[13]) m_abt[k] = 0;
        if (!din[12]) m_err[k] = 0;
      end
      if (m_st[k] == 0) begin
        if (cpu) m_cfg[k] = din[7:0];
        if (cpu && din[15]) begin
          ns = 1; m_suc[k] = 0; m_abt[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end
      end else if (m_st[k] == 1) begin
        if (txstart) ns = 2;
        else if (cpu && din[13]) begin ns = 0; m_abt[k] = 1; end
      end else begin
        if (cpu && din[13]) m_ab[k] = 1;
        if (txok) begin ns = 0; m_suc[k] = 1; end
        else if (txerr || txlost) begin
          m_cnt[k] = m_cnt[k] < 15 ? m_cnt[k] + 1 : 15;
          if (m_ab[k]) begin ns = 0; m_abt[k] = 1; end
          else if (m_cnt[k] == maxr[k]) begin ns = 0; m_err[k] = 1; end
          else ns = 1;
        end
      end
      m_irq[k] = m_cfg[k][7] && m_st[k] != 0 && ns == 0;
      if (ns != 2) m_ab[k] = 0;
      m_st[k] = ns;
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      check($sformatf("regout%0d", k), k == 0 ? ro0 : ro1, exp_reg(k));
      check($sformatf("txreq%0d", k), {15'd0, k == 0 ? txreq0 : txreq1}, {15'd0, m_st[k] == 1});
      check($sformatf("irq%0d", k), {15'd0, k == 0 ? irq0 : irq1}, {15'd0, m_irq[k]});
    end

  task automatic cyc(input logic c, input logic [15:0] d, input logic s, input logic o, input logic l, input logic e);
    cpu = c; din = d; txstart = s; txok = o; txlost = l; txerr = e;
    @(posedge clk);
    model_step();
    #1;
    cpu = 0; din = 0; txstart = 0; txok = 0; txlost = 0; txerr = 0;
  endtask

  task automatic async_reset();
    #1 rst = 0;
    #1;
    check("async_regout", ro0, 16'h0000);
    check("async_txreq", {15'd0, txreq0}, 16'h0000);
    model_reset();
    #5 rst = 1;
  endtask

  initial begin
    rst = 0; cpu = 0; din = 0; txstart = 0; txok = 0; txlost = 0; txerr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_regout", ro0, 16'h0000);
    rst = 1;
    cyc(1, 16'h80A3, 0, 0, 0, 0);
    check("req_regout", ro0, 16'h80A3);
    check("req_txreq", {15'd0, txreq0}, 16'h0001);
    cyc(0, 0, 1, 0, 0, 0);
    check("start_txreq", {15'd0, txreq0}, 16'h0000);
    cyc(0, 0, 0, 1, 0, 0);
    check("ok_regout", ro0, 16'h40A3);
    check("ok_irq", {15'd0, irq0}, 16'h0001);
    cyc(0, 0, 0, 0, 0, 0);
    check("irq_one_cycle", {15'd0, irq0}, 16'h0000);
    cyc(1, 16'h8000, 0, 0, 0, 0);
    repeat (2) begin cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0, 1); end
    check("maxretry2_regout_hi", {8'd0, ro1[15:8]}, 16'h0012);
    check("maxretry2_txreq", {15'd0, txreq1}, 16'h0000);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    check("retry3_regout_hi", {8'd0, ro0[15:8]}, 16'h0043);
    cyc(1, 16'h80A3, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 16'h0011, 0, 0, 0, 0);
    check("cfg_locked", {8'd0, ro0[7:0]}, 16'h00A3);
    cyc(1, 16'h0000, 0, 1, 0, 0);
    check("set_beats_clear", {15'd0, ro0[14]}, 16'h0001);
    cyc(1, 16'h8000, 0, 0, 0, 0); cyc(1, 16'h2000, 0, 0, 0, 0);
    check("abort_pending", {8'd0, ro0[15:8]}, 16'h0020);
    cyc(1, 16'h8000, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0); cyc(1, 16'h2000, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    check("abort_then_ok", {8'd0, ro0[15:8]}, 16'h0040);
    cyc(1, 16'h8000, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0); cyc(1, 16'h2000, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
    check("abort_then_lost", {8'd0, ro0[15:8]}, 16'h0021);
    cyc(1, 16'h8000, 0, 0, 0, 0);
    repeat (15) begin cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0); end
    check("maxretry15", {8'd0, ro0[15:8]}, 16'h001F);
    cyc(1, 16'h8080, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    async_reset();
    cyc(0, 0, 0, 1, 0, 0);
    check("ok_after_reset", ro0, 16'h0000);
    check("no_irq_after_reset", {15'd0, irq0}, 16'h0000);
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      d[14:12] = 3'($urandom) | 3'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset();
      cyc($urandom_range(0, 11) == 0, d, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
